// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the femto bus arbiter.
//   XLEN / BUS_WIDTH / BUS_ACC_CNT : femto bus widths
//   BUS_TIMEOUT                    : default watchdog limit in BUSY cycles
//   arb_state_e                    : arbiter ownership state
//   owner_e                        : round-robin history (last granted master)
package bus_arbiter_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned BUS_WIDTH   = 32;
  localparam int unsigned BUS_ACC_CNT = 3;
  localparam int unsigned BUS_ACC_W   = $clog2(BUS_ACC_CNT);
  localparam int unsigned BUS_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // Counter width able to hold 0..t; never narrower than one bit.
  function automatic int unsigned wd_cnt_width(input int unsigned t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Saturating BUSY-cycle counter for the bus arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   i_clr      : clear the count (takes priority over i_en)
//   i_en       : count one cycle
//   o_expire   : count has reached TIMEOUT_CYCLES-1 (never when TIMEOUT_CYCLES = 0)
module bus_watchdog
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CNT_W = wd_cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Count k is seen in BUSY cycle k+1, so matching TIMEOUT_CYCLES-1 fires
  // in BUSY cycle TIMEOUT_CYCLES.
  always_comb begin
    o_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the femto bus decoder.
//   clk, rst                         : clock, synchronous active-high reset
//   mi_* (req/addr/w_rb/acc/wdata)   : fetch master request, held until resp/fault
//   mi_resp/mi_rdata/mi_fault        : fetch master completion
//   md_*                             : data master, same as mi_*
//   s_req/s_addr/s_w_rb/s_acc/s_wdata: forwarded request to the decoder
//   s_resp/s_rdata/s_fault           : decoder completion (s_fault comb. with s_req)
// Grant and forwarding happen in the request cycle; one transaction at a time.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mi_req,
  input  logic [XLEN-1:0]      mi_addr,
  input  logic                 mi_w_rb,
  input  logic [BUS_ACC_W-1:0] mi_acc,
  input  logic [BUS_WIDTH-1:0] mi_wdata,
  output logic                 mi_resp,
  output logic [BUS_WIDTH-1:0] mi_rdata,
  output logic                 mi_fault,
  input  logic                 md_req,
  input  logic [XLEN-1:0]      md_addr,
  input  logic                 md_w_rb,
  input  logic [BUS_ACC_W-1:0] md_acc,
  input  logic [BUS_WIDTH-1:0] md_wdata,
  output logic                 md_resp,
  output logic [BUS_WIDTH-1:0] md_rdata,
  output logic                 md_fault,
  output logic                 s_req,
  output logic [XLEN-1:0]      s_addr,
  output logic                 s_w_rb,
  output logic [BUS_ACC_W-1:0] s_acc,
  output logic [BUS_WIDTH-1:0] s_wdata,
  input  logic                 s_resp,
  input  logic [BUS_WIDTH-1:0] s_rdata,
  input  logic                 s_fault
);

  arb_state_e r_state;
  arb_state_e w_next_state;
  owner_e     r_last;

  logic w_busy;
  logic w_sel_d;    // data master selected this cycle
  logic w_active;   // a transaction is in flight or being granted this cycle
  logic w_expire;
  logic w_timeout;
  logic w_resp;
  logic w_fault;
  logic w_done;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (~w_busy | w_done),
    .i_en    (w_busy),
    .o_expire(w_expire)
  );

  // State and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= OWN_FETCH;
    end else begin
      r_state <= w_next_state;
      // History follows every grant, including ones completed in the grant cycle.
      if ((r_state == ST_IDLE) && w_active) begin
        r_last <= w_sel_d ? OWN_DATA : OWN_FETCH;
      end
    end
  end

  // Ownership, termination and next state.
  always_comb begin
    w_busy       = (r_state != ST_IDLE);
    w_sel_d      = 1'b0;
    w_active     = 1'b0;
    w_next_state = r_state;
    unique case (r_state)
      ST_BUSY_I: begin
        w_sel_d  = 1'b0;
        w_active = 1'b1;
      end
      ST_BUSY_D: begin
        w_sel_d  = 1'b1;
        w_active = 1'b1;
      end
      default: begin
        w_sel_d  = md_req & (~mi_req | (r_last == OWN_FETCH));
        w_active = mi_req | md_req;
      end
    endcase
    w_active  = w_active & ~rst;
    w_timeout = w_busy & w_expire;
    w_resp    = w_active & s_resp;
    w_fault   = w_active & ~s_resp & (s_fault | w_timeout);
    w_done    = w_resp | w_fault;
    if (w_done) begin
      w_next_state = ST_IDLE;
    end else if ((r_state == ST_IDLE) && w_active) begin
      w_next_state = w_sel_d ? ST_BUSY_D : ST_BUSY_I;
    end
  end

  // Bus muxing and completion routing; idle bus carries fetch fields.
  always_comb begin
    s_req    = w_active & (w_sel_d ? md_req : mi_req) & ~w_timeout;
    s_addr   = w_sel_d ? md_addr  : mi_addr;
    s_w_rb   = w_sel_d ? md_w_rb  : mi_w_rb;
    s_acc    = w_sel_d ? md_acc   : mi_acc;
    s_wdata  = w_sel_d ? md_wdata : mi_wdata;
    mi_resp  = w_resp  & ~w_sel_d;
    md_resp  = w_resp  &  w_sel_d;
    mi_fault = w_fault & ~w_sel_d;
    md_fault = w_fault &  w_sel_d;
    mi_rdata = s_rdata;
    md_rdata = s_rdata;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave-port arbiter for the femto memory bus. It shares the single bus path into the slave address decoder between the instruction-fetch master and the data master. Grants are round-robin, one outstanding transaction at a time. A watchdog terminates transactions that never respond. It sits between the core's fetch/LSU ports and the decoder's master port, and routes the decoder's bus fault back to the owning master.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, cycles in BUSY without `s_resp` before a forced fault; 0 disables the watchdog.

Ports (widths from femto.vh):
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- mi_req  in  1  fetch master request, level
- mi_addr  in  XLEN  fetch address
- mi_w_rb  in  1  1 = write, 0 = read
- mi_acc  in  clog2(BUS_ACC_CNT)  access size
- mi_wdata  in  BUS_WIDTH  write data
- mi_resp  out  1  one-cycle completion pulse
- mi_rdata  out  BUS_WIDTH  read data, valid with `mi_resp`
- mi_fault  out  1  one-cycle fault pulse (decode fault or timeout)
- md_req, md_addr, md_w_rb, md_acc, md_wdata, md_resp, md_rdata, md_fault: data master, same as the `mi_*` ports
- s_req, s_addr, s_w_rb, s_acc, s_wdata  out: to decoder master side
- s_resp  in  1, s_rdata  in  BUS_WIDTH: from decoder
- s_fault  in  1  decoder "no slave selected", combinational with `s_req`

## Operation
- **Protocol.** A master raises req with stable addr, w_rb, acc and wdata, and holds them until its resp or fault cycle. Dropping req early is a protocol violation. In that case the only guarantee is that the lock is released on resp, fault or timeout.
- **States:**
  - IDLE: no owner.
  - BUSY_I: fetch master owns the bus.
  - BUSY_D: data master owns the bus.
- **Arbitration in IDLE:**
  - Only one req high: that master wins.
  - Both high: the master not recorded in `last` wins.
  - The winner's request is forwarded combinationally in the same cycle. The state moves to BUSY_x and `last` is updated to the winner.
- **In BUSY_x:**
  - `s_*` carry the owner's fields and `s_req` equals the owner's req.
  - The non-owner's resp and fault are 0.
- **Termination.** Evaluated in the grant cycle as well as in BUSY cycles:
  - `s_resp` → owner resp = 1, then go to IDLE.
  - else `s_fault` → owner fault = 1, then go to IDLE.
  - else watchdog expiry → owner fault = 1, `s_req` forced to 0 that cycle, then go to IDLE.
  - Priority: resp > s_fault > timeout.
- **Read data.** `mi_rdata` and `md_rdata` both equal `s_rdata` at all times; they are meaningful only with resp.
- **Watchdog counter:**
  - Width clog2(TIMEOUT_CYCLES+1).
  - Cleared in IDLE, incremented each BUSY cycle without termination, saturating.
  - Expiry when count == TIMEOUT_CYCLES − 1 in a BUSY cycle, i.e. the fault pulse lands in BUSY cycle number TIMEOUT_CYCLES.
- **Idle bus.** In IDLE with no req, `s_req` = 0 and `s_addr`, `s_w_rb`, `s_acc`, `s_wdata` carry the fetch master's fields.

## Timing
- **Reset values:** state IDLE, `last` = fetch (data wins the first tie), counter 0.
- **During rst:** `s_req`, all resp and all fault outputs are 0 regardless of inputs.
- **Added latency:** zero. Grant and forwarding happen in the request cycle, and resp is passed through combinationally.
- **Same-cycle completion:** if the slave answers in the grant cycle, the transaction completes from IDLE in that cycle. The arbiter stays in IDLE and `last` is still updated.
- **Throughput:** after a completion cycle, arbitration for the next transaction is in the following cycle. Back-to-back transactions therefore have at least one cycle between grants. No combinational path runs from resp to the new grant.
- **Reset mid-transaction:** the arbiter returns to IDLE immediately and no resp or fault is emitted for the aborted transaction.

## Structure
- The widths XLEN, BUS_WIDTH and BUS_ACC_CNT come from femto.vh. Add `BUS_TIMEOUT` to femto.vh as the default for TIMEOUT_CYCLES.
- State encoding is a module-local localparam.
- The single natural sub-module is `bus_watchdog`: a saturating counter with clear, enable and expire.
- Everything else (state register, `last` register, output muxing) is flat.

## Test plan
1. **Single fetch.** `mi_req` with addr 0x0000_0100; `s_resp` two cycles later with rdata 0xDEADBEEF → `s_addr` = 0x100 from cycle 0; `mi_resp` = 1 with `mi_rdata` 0xDEADBEEF in cycle 2; `md_resp` = 0 throughout.
2. **Round-robin.** Both req from the first cycle after reset; slave responds after 1 cycle each time → grant order is D, I, D, I across four transactions, with one IDLE cycle between each.
3. **Decode fault.** `md_req` to an unmapped address; `s_fault` high in the grant cycle → `md_fault` pulses in that cycle, `md_resp` = 0, next state IDLE.
4. **Timeout.** TIMEOUT_CYCLES = 4, `mi_req`, slave never responds → `mi_fault` in BUSY cycle 4 with `s_req` = 0 that cycle; a pending `md_req` is granted the next cycle.
5. **Same-cycle resp.** `s_resp` combinational with `s_req` → `mi_resp` in the request cycle; state remains IDLE.
6. **Reset mid-transaction.** rst asserted in BUSY_D for one cycle → no `md_resp`/`md_fault`; after reset, with both masters requesting, data wins.
